bd_multi_ep_controller: RTL and testbench

Parametrised next-generation bulk-data transfer controller. Serves NUM_EP bulk endpoints from one protocol FSM, and adds behaviour the single-endpoint controller lacks:
- per-endpoint DATA0/DATA1 toggle tracking
- NAK on buffer not ready
- handshake timeout
- bounded IN retry with STALL/halt
Sits between the packet decoder (token/data/handshake in) and the packet encoder (handshake/data out), and drives endpoint buffer commit/consume strobes.

---
 rtl/bd_multi_ep_controller.sv | 214 +++++++++++++++++++++
 tb/tb_bd_multi_ep_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bd_multi_ep_controller.sv
// Multi-endpoint bulk transfer controller: one protocol FSM that serves
// NUM_EP bulk endpoints. It tracks a DATA0/DATA1 toggle per endpoint,
// NAKs when a buffer is not ready, and times out handshake/data waits.
// Each endpoint halts after MAX_RETRY consecutive failed IN transactions.
module bd_multi_ep_controller #(
  parameter int NUM_EP         = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRY      = 3,
  localparam int EP_W          = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pckt_valid,
  input  logic [1:0]        pckt_rcvd,
  input  logic [3:0]        ep_num,
  input  logic              data_pid,
  input  logic              crc_ok,
  input  logic              hs_ack,
  input  logic              tx_complete,
  input  logic [NUM_EP-1:0] ep_tx_ready,
  input  logic [NUM_EP-1:0] ep_rx_ready,
  input  logic [NUM_EP-1:0] ep_clear,
  output logic              tx_en,
  output logic              send_data,
  output logic              tx_pid,
  output logic              send_ack,
  output logic              send_nack,
  output logic              send_stall,
  output logic              rx_en,
  output logic [EP_W-1:0]   ep_sel,
  output logic              data_commit,
  output logic              data_consume,
  output logic [NUM_EP-1:0] ep_halt,
  output logic              err_timeout,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] PKT_HS   = 2'b00;
  localparam logic [1:0] PKT_IN   = 2'b01;
  localparam logic [1:0] PKT_OUT  = 2'b10;
  localparam logic [1:0] PKT_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_DATA,
    S_WAIT_HS,
    S_WAIT_DATA,
    S_SEND_ACK,
    S_SEND_NAK,
    S_SEND_STALL
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [EP_W-1:0]   ep_sel_next;
  logic [NUM_EP-1:0] toggle;
  logic [3:0]        retry [NUM_EP];
  logic [TMR_W-1:0]  timer;

  logic              tok_valid;
  logic [EP_W-1:0]   tok_idx;
  logic              tok_ok;
  logic              timeout;

  logic              ev_commit;
  logic              ev_hs_ok;
  logic              ev_hs_fail;
  logic              ev_timeout;

  // Token decode shared by IN and OUT: out-of-range or halted endpoints stall
  always_comb begin
    tok_valid = ({1'b0, ep_num} < 5'(NUM_EP));
    tok_idx   = ep_num[EP_W-1:0];
    tok_ok    = tok_valid && !ep_halt[tok_idx];
    timeout   = (timer == TMR_W'(TIMEOUT_CYCLES - 1)) && !pckt_valid;
  end

  // Next-state decision, per-transaction events and Moore outputs
  always_comb begin
    state_next  = state;
    ep_sel_next = ep_sel;
    ev_commit   = 1'b0;
    ev_hs_ok    = 1'b0;
    ev_hs_fail  = 1'b0;
    ev_timeout  = 1'b0;
    tx_en       = 1'b0;
    send_data   = 1'b0;
    tx_pid      = 1'b0;
    send_ack    = 1'b0;
    send_nack   = 1'b0;
    send_stall  = 1'b0;
    rx_en       = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pckt_valid && pckt_rcvd == PKT_IN) begin
          ep_sel_next = tok_idx;
          if (!tok_ok)                   state_next = S_SEND_STALL;
          else if (ep_tx_ready[tok_idx]) state_next = S_TX_DATA;
          else                           state_next = S_SEND_NAK;
        end else if (pckt_valid && pckt_rcvd == PKT_OUT) begin
          ep_sel_next = tok_idx;
          state_next  = tok_ok ? S_WAIT_DATA : S_SEND_STALL;
        end
      end
      S_TX_DATA: begin
        tx_en     = 1'b1;
        send_data = 1'b1;
        tx_pid    = toggle[ep_sel];
        if (tx_complete) state_next = S_WAIT_HS;
      end
      S_WAIT_HS: begin
        rx_en = 1'b1;
        if (pckt_valid) begin
          // Anything other than an ACK handshake counts as a failed attempt
          if (pckt_rcvd == PKT_HS && hs_ack) ev_hs_ok = 1'b1;
          else                                ev_hs_fail = 1'b1;
          state_next = S_IDLE;
        end else if (timeout) begin
          ev_hs_fail = 1'b1;
          ev_timeout = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        rx_en = 1'b1;
        if (pckt_valid) begin
          if (pckt_rcvd != PKT_DATA || !crc_ok) begin
            state_next = S_IDLE;
          end else if (!ep_rx_ready[ep_sel]) begin
            state_next = S_SEND_NAK;
          end else begin
            // A PID mismatch is a host retransmission: ACK it but keep the data out
            ev_commit  = (data_pid == toggle[ep_sel]);
            state_next = S_SEND_ACK;
          end
        end else if (timeout) begin
          ev_timeout = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_SEND_ACK: begin
        tx_en    = 1'b1;
        send_ack = 1'b1;
        if (tx_complete) state_next = S_IDLE;
      end
      S_SEND_NAK: begin
        tx_en     = 1'b1;
        send_nack = 1'b1;
        if (tx_complete) state_next = S_IDLE;
      end
      S_SEND_STALL: begin
        tx_en      = 1'b1;
        send_stall = 1'b1;
        if (tx_complete) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, latched endpoint, wait timer and one-cycle transition strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ep_sel       <= '0;
      timer        <= '0;
      data_commit  <= 1'b0;
      data_consume <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_next;
      ep_sel       <= ep_sel_next;
      data_commit  <= ev_commit;
      data_consume <= ev_hs_ok;
      err_timeout  <= ev_timeout;
      if (state_next != state)
        timer <= '0;
      else if (state == S_WAIT_HS || state == S_WAIT_DATA)
        timer <= timer + 1'b1;
    end
  end

  // Per-endpoint toggle, retry and halt bookkeeping; a host clear overrides the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle  <= '0;
      ep_halt <= '0;
      for (int i = 0; i < NUM_EP; i++) retry[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (ep_clear[i]) begin
          toggle[i]  <= 1'b0;
          ep_halt[i] <= 1'b0;
          retry[i]   <= '0;
        end else if (ep_sel == EP_W'(i)) begin
          if (ev_commit || ev_hs_ok) toggle[i] <= ~toggle[i];
          if (ev_hs_ok) begin
            retry[i] <= '0;
          end else if (ev_hs_fail) begin
            if (retry[i] + 4'd1 == 4'(MAX_RETRY)) begin
              ep_halt[i] <= 1'b1;
              retry[i]   <= '0;
            end else begin
              retry[i] <= retry[i] + 4'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bd_multi_ep_controller.sv
// Directed bench for bd_multi_ep_controller with an expectation queue:
// each step pushes what it requires, then pops and asserts after driving.
module tb_bd_multi_ep_controller;

  localparam int NUM_EP  = 4;
  localparam int TIMEOUT = 16;
  localparam int RETRIES = 3;
  localparam int EP_W    = 2;

  // Output vector bits: {tx_en, send_data, tx_pid, send_ack, send_nack, send_stall, rx_en, busy}
  localparam logic [7:0] O_IDLE  = 8'h00;
  localparam logic [7:0] O_WAIT  = 8'h03;
  localparam logic [7:0] O_DATA0 = 8'hC1;
  localparam logic [7:0] O_DATA1 = 8'hE1;
  localparam logic [7:0] O_ACK   = 8'h91;
  localparam logic [7:0] O_NAK   = 8'h89;
  localparam logic [7:0] O_STALL = 8'h85;

  // Strobe vector bits: {data_commit, data_consume, err_timeout}
  localparam logic [2:0] S_NONE    = 3'b000;
  localparam logic [2:0] S_COMMIT  = 3'b100;
  localparam logic [2:0] S_CONSUME = 3'b010;
  localparam logic [2:0] S_TIMEOUT = 3'b001;

  logic              clk = 1'b0;
  logic              rst;
  logic              pckt_valid;
  logic [1:0]        pckt_rcvd;
  logic [3:0]        ep_num;
  logic              data_pid;
  logic              crc_ok;
  logic              hs_ack;
  logic              tx_complete;
  logic [NUM_EP-1:0] ep_tx_ready;
  logic [NUM_EP-1:0] ep_rx_ready;
  logic [NUM_EP-1:0] ep_clear;
  logic              tx_en;
  logic              send_data;
  logic              tx_pid;
  logic              send_ack;
  logic              send_nack;
  logic              send_stall;
  logic              rx_en;
  logic [EP_W-1:0]   ep_sel;
  logic              data_commit;
  logic              data_consume;
  logic [NUM_EP-1:0] ep_halt;
  logic              err_timeout;
  logic              busy;

  int          test_count = 0;
  int          fail_count = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  bd_multi_ep_controller #(
    .NUM_EP(NUM_EP),
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRY(RETRIES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pckt_valid(pckt_valid),
    .pckt_rcvd(pckt_rcvd),
    .ep_num(ep_num),
    .data_pid(data_pid),
    .crc_ok(crc_ok),
    .hs_ack(hs_ack),
    .tx_complete(tx_complete),
    .ep_tx_ready(ep_tx_ready),
    .ep_rx_ready(ep_rx_ready),
    .ep_clear(ep_clear),
    .tx_en(tx_en),
    .send_data(send_data),
    .tx_pid(tx_pid),
    .send_ack(send_ack),
    .send_nack(send_nack),
    .send_stall(send_stall),
    .rx_en(rx_en),
    .ep_sel(ep_sel),
    .data_commit(data_commit),
    .data_consume(data_consume),
    .ep_halt(ep_halt),
    .err_timeout(err_timeout),
    .busy(busy)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  function automatic logic [7:0] out_vec();
    return {tx_en, send_data, tx_pid, send_ack, send_nack, send_stall, rx_en, busy};
  endfunction

  function automatic logic [2:0] strb_vec();
    return {data_commit, data_consume, err_timeout};
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic check_output(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    test_count++;
    if (exp_q.size() == 0) begin
      fail_count++;
      $display("[TB] FAIL scoreboard_empty observed=%0h required=none", observed);
      return;
    end
    tag      = tag_q.pop_front();
    expected = exp_q.pop_front();
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h required=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] cls, input logic [3:0] ep,
                                input logic pid, input logic crc, input logic ack);
    @(negedge clk);
    pckt_valid = 1'b1;
    pckt_rcvd  = cls;
    ep_num     = ep;
    data_pid   = pid;
    crc_ok     = crc;
    hs_ack     = ack;
    @(negedge clk);
    pckt_valid = 1'b0;
  endtask

  task automatic pulse_complete();
    @(negedge clk);
    tx_complete = 1'b1;
    @(negedge clk);
    tx_complete = 1'b0;
  endtask

  task automatic wait_timeout(output int n);
    n = 0;
    while (!err_timeout && n < 3 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pckt_valid = 1'b0; pckt_rcvd = 2'b00; ep_num = 4'd0; data_pid = 1'b0;
    crc_ok = 1'b0; hs_ack = 1'b0; tx_complete = 1'b0;
    ep_tx_ready = 4'b0011; ep_rx_ready = 4'b1111; ep_clear = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset state
    expect_val("reset_outs", O_IDLE);  expect_val("reset_strobes", S_NONE);
    expect_val("reset_halt", 4'b0000); expect_val("reset_ep_sel", 2'd0);
    check_output(out_vec()); check_output(strb_vec());
    check_output(ep_halt);   check_output(ep_sel);
    rst = 1'b0;

    // OUT ep2 with DATA0: commit and ACK; second DATA0 is a retransmission
    expect_val("out2_wait", O_WAIT); expect_val("out2_sel", 2'd2);
    apply_stimulus(2'b10, 4'd2, 1'b0, 1'b0, 1'b0);
    check_output(out_vec()); check_output(ep_sel);
    expect_val("out2_ack", O_ACK); expect_val("out2_commit", S_COMMIT);
    apply_stimulus(2'b11, 4'd0, 1'b0, 1'b1, 1'b0);
    check_output(out_vec()); check_output(strb_vec());
    expect_val("out2_ack_hold", O_ACK); expect_val("out2_commit_1cyc", S_NONE);
    @(negedge clk);
    check_output(out_vec()); check_output(strb_vec());
    expect_val("out2_ack_done", O_IDLE);
    pulse_complete();
    check_output(out_vec());
    apply_stimulus(2'b10, 4'd2, 1'b0, 1'b0, 1'b0);
    expect_val("retx_ack", O_ACK); expect_val("retx_no_commit", S_NONE);
    apply_stimulus(2'b11, 4'd0, 1'b0, 1'b1, 1'b0);
    check_output(out_vec()); check_output(strb_vec());
    pulse_complete();
    apply_stimulus(2'b10, 4'd2, 1'b0, 1'b0, 1'b0);
    expect_val("data1_commit", S_COMMIT);
    apply_stimulus(2'b11, 4'd0, 1'b1, 1'b1, 1'b0);
    check_output(strb_vec());
    pulse_complete();

    // IN ep1: DATA0, ACK consumes, next IN uses DATA1
    expect_val("in1_data0", O_DATA0); expect_val("in1_sel", 2'd1);
    apply_stimulus(2'b01, 4'd1, 1'b0, 1'b0, 1'b0);
    check_output(out_vec()); check_output(ep_sel);
    expect_val("in1_wait_hs", O_WAIT);
    pulse_complete();
    check_output(out_vec());
    expect_val("in1_consume", S_CONSUME); expect_val("in1_idle", O_IDLE);
    apply_stimulus(2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
    check_output(strb_vec()); check_output(out_vec());
    expect_val("in1_data1", O_DATA1);
    apply_stimulus(2'b01, 4'd1, 1'b0, 1'b0, 1'b0);
    check_output(out_vec());
    pulse_complete();
    expect_val("in1_consume2", S_CONSUME);
    apply_stimulus(2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
    check_output(strb_vec());

    // IN to an endpoint without data NAKs; out-of-range endpoint stalls
    expect_val("in3_nak", O_NAK);
    apply_stimulus(2'b01, 4'd3, 1'b0, 1'b0, 1'b0);
    check_output(out_vec());
    pulse_complete();
    expect_val("in5_stall", O_STALL);
    apply_stimulus(2'b01, 4'd5, 1'b0, 1'b0, 1'b0);
    check_output(out_vec());
    pulse_complete();

    // OUT into a full buffer NAKs without committing
    ep_rx_ready = 4'b1011;
    apply_stimulus(2'b10, 4'd2, 1'b0, 1'b0, 1'b0);
    expect_val("out_full_nak", O_NAK); expect_val("out_full_no_commit", S_NONE);
    apply_stimulus(2'b11, 4'd0, 1'b0, 1'b1, 1'b0);
    check_output(out_vec()); check_output(strb_vec());
    pulse_complete();
    ep_rx_ready = 4'b1111;

    // ep0: one good IN, then three timeouts halt it
    apply_stimulus(2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
    pulse_complete();
    apply_stimulus(2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < RETRIES; k++) begin
      expect_val("in0_retry_data1", O_DATA1);
      apply_stimulus(2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
      check_output(out_vec());
      pulse_complete();
      expect_val("in0_timeout_cycles", TIMEOUT);
      expect_val("in0_timeout_strobe", S_TIMEOUT);
      expect_val("in0_halt", (k == RETRIES - 1) ? 4'b0001 : 4'b0000);
      wait_timeout(n);
      check_output(n); check_output(strb_vec()); check_output(ep_halt);
    end
    expect_val("in0_halted_stall", O_STALL);
    apply_stimulus(2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
    check_output(out_vec());
    pulse_complete();
    @(negedge clk); ep_clear = 4'b0001;
    @(negedge clk); ep_clear = 4'b0000;
    expect_val("clear_halt", 4'b0000);
    check_output(ep_halt);
    expect_val("clear_toggle_data0", O_DATA0);
    apply_stimulus(2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
    check_output(out_vec());
    pulse_complete();
    apply_stimulus(2'b00, 4'd0, 1'b0, 1'b0, 1'b1);

    // Bad CRC returns silently; missing DATA times out
    apply_stimulus(2'b10, 4'd2, 1'b0, 1'b0, 1'b0);
    expect_val("badcrc_idle", O_IDLE); expect_val("badcrc_strobes", S_NONE);
    apply_stimulus(2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
    check_output(out_vec()); check_output(strb_vec());
    apply_stimulus(2'b10, 4'd2, 1'b0, 1'b0, 1'b0);
    expect_val("out_timeout_cycles", TIMEOUT);
    expect_val("out_timeout_strobe", S_TIMEOUT);
    expect_val("out_timeout_idle", O_IDLE);
    wait_timeout(n);
    check_output(n); check_output(strb_vec()); check_output(out_vec());

    // Reset during TX_DATA with ep1 toggle at DATA1
    apply_stimulus(2'b01, 4'd1, 1'b0, 1'b0, 1'b0);
    pulse_complete();
    apply_stimulus(2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val("pre_rst_data1", O_DATA1);
    apply_stimulus(2'b01, 4'd1, 1'b0, 1'b0, 1'b0);
    check_output(out_vec());
    rst = 1'b1;
    #1;
    expect_val("rst_async_outs", O_IDLE); expect_val("rst_async_strobes", S_NONE);
    check_output(out_vec()); check_output(strb_vec());
    @(negedge clk);
    expect_val("rst_no_consume", S_NONE);
    check_output(strb_vec());
    rst = 1'b0;
    expect_val("post_rst_data0", O_DATA0);
    apply_stimulus(2'b01, 4'd1, 1'b0, 1'b0, 1'b0);
    check_output(out_vec());
    pulse_complete();
    expect_val("post_rst_consume", S_CONSUME);
    apply_stimulus(2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
    check_output(strb_vec());

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
